seq_alu_calc_display: RTL and testbench

Parametrised successor to the 4-bit calculator. It is an N-bit ALU with registered single-cycle logic and arithmetic ops, plus multi-cycle shift-add multiply and restoring divide, all under a start/busy/done handshake. The held result drives a time-multiplexed, active-low, hex 7-segment display with DIGITS anodes. It sits at board top level, between the switches/buttons and the Anode_Activate/LED_out pins.

---
 rtl/seq_alu_calc_display_if.sv | 28 ++
 rtl/seq_alu_calc_display.sv | 184 ++++++++++++++++++
 tb/tb_seq_alu_calc_display.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_calc_display_if.sv
// Operand, handshake, result and display bus of the sequential ALU calculator.
// master drives operands and start; slave is the ALU that drives everything else.
interface seq_alu_calc_display_if #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 4
);
   logic [WIDTH-1:0]   X;
   logic [WIDTH-1:0]   Y;
   logic [2:0]         Op;
   logic               start;
   logic               busy;
   logic               done;
   logic [2*WIDTH-1:0] result;
   logic               carry;
   logic               div_by_zero;
   logic [DIGITS-1:0]  Anode_Activate;
   logic [6:0]         LED_out;

   modport master (
      output X, Y, Op, start,
      input  busy, done, result, carry, div_by_zero, Anode_Activate, LED_out
   );

   modport slave (
      input  X, Y, Op, start,
      output busy, done, result, carry, div_by_zero, Anode_Activate, LED_out
   );
endinterface

// File: rtl/seq_alu_calc_display.sv
// N-bit ALU with single-cycle logic/arithmetic, multi-cycle shift-add multiply and
// restoring divide, driving a multiplexed active-low hex 7-segment display.
module seq_alu_calc_display #(
   parameter int WIDTH       = 8,
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 100000
) (
   input logic                  clock_100Mhz,
   input logic                  reset,
   seq_alu_calc_display_if.slave io
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR   = 3'b011,
      OP_XOR = 3'b100, OP_MUL = 3'b101, OP_DIV = 3'b110, OP_PASS = 3'b111
   } op_e;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'h0: seg7 = 7'b0000001;  4'h1: seg7 = 7'b1001111;
         4'h2: seg7 = 7'b0010010;  4'h3: seg7 = 7'b0000110;
         4'h4: seg7 = 7'b1001100;  4'h5: seg7 = 7'b0100100;
         4'h6: seg7 = 7'b0100000;  4'h7: seg7 = 7'b0001111;
         4'h8: seg7 = 7'b0000000;  4'h9: seg7 = 7'b0000100;
         4'hA: seg7 = 7'b0001000;  4'hB: seg7 = 7'b1100000;
         4'hC: seg7 = 7'b0110001;  4'hD: seg7 = 7'b1000010;
         4'hE: seg7 = 7'b0110000;  default: seg7 = 7'b0111000;
      endcase
   endfunction

   state_e             state_q, state_d;
   logic [2*WIDTH-1:0] a_q, a_d, acc_q, acc_d, result_q, result_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               carry_q, carry_d, dbz_q, dbz_d, done_q, done_d;
   logic [RW-1:0]      refresh_q, refresh_d;
   logic [SW-1:0]      idx_q, idx_d;
   logic [DIGITS-1:0]  anode_q, anode_d;
   logic [6:0]         led_q, led_d;

   op_e                op;
   logic [WIDTH:0]     sum, diff, trial, trial_sub;
   logic               ge;
   logic [WIDTH-1:0]   rem_next;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      carry_d  = carry_q;
      dbz_d    = dbz_q;
      done_d   = 1'b0;

      op        = op_e'(io.Op);
      sum       = {1'b0, io.X} + {1'b0, io.Y};
      diff      = {1'b0, io.X} - {1'b0, io.Y};
      // Restoring step: shift the next dividend bit into the partial remainder.
      trial     = {acc_q[WIDTH-1:0], a_q[WIDTH-1]};
      trial_sub = trial - {1'b0, b_q};
      ge        = (trial >= {1'b0, b_q});
      rem_next  = ge ? trial_sub[WIDTH-1:0] : trial[WIDTH-1:0];

      case (state_q)
         S_IDLE: begin
            if (io.start) begin
               if (op == OP_MUL || op == OP_DIV) begin
                  a_d             = '0;
                  a_d[WIDTH-1:0]  = io.X;
                  b_d             = io.Y;
                  acc_d           = '0;
                  cnt_d           = '0;
                  state_d         = (op == OP_MUL) ? S_MUL : S_DIV;
               end else begin
                  result_d = '0;
                  carry_d  = 1'b0;
                  dbz_d    = 1'b0;
                  done_d   = 1'b1;
                  case (op)
                     OP_ADD:  begin result_d[WIDTH-1:0] = sum[WIDTH-1:0];  carry_d = sum[WIDTH];  end
                     OP_SUB:  begin result_d[WIDTH-1:0] = diff[WIDTH-1:0]; carry_d = diff[WIDTH]; end
                     OP_AND:  result_d[WIDTH-1:0] = io.X & io.Y;
                     OP_OR:   result_d[WIDTH-1:0] = io.X | io.Y;
                     OP_XOR:  result_d[WIDTH-1:0] = io.X ^ io.Y;
                     default: result_d[WIDTH-1:0] = io.X;
                  endcase
               end
            end
         end
         S_MUL: begin
            if (b_q[0]) acc_d = acc_q + a_q;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               result_d = acc_d;
               carry_d  = 1'b0;
               dbz_d    = 1'b0;
               done_d   = 1'b1;
               state_d  = S_IDLE;
            end
         end
         S_DIV: begin
            acc_d              = '0;
            acc_d[WIDTH-1:0]   = rem_next;
            a_d                = a_q << 1;
            a_d[0]             = ge;
            cnt_d              = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               result_d = {rem_next, a_d[WIDTH-1:0]};
               carry_d  = 1'b0;
               dbz_d    = (b_q == '0);
               done_d   = 1'b1;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   logic [4*DIGITS-1:0] disp;

   always_comb begin
      refresh_d = refresh_q + 1'b1;
      idx_d     = idx_q;
      if (refresh_q == RW'(REFRESH_DIV - 1)) begin
         refresh_d = '0;
         idx_d     = (idx_q == SW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end
      disp                = '0;
      disp[2*WIDTH-1:0]   = result_d;
      anode_d             = ~(DIGITS'(1) << idx_d);
      led_d               = seg7(disp[4*idx_d +: 4]);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge clock_100Mhz) begin
      if (reset) begin
         state_q   <= S_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         result_q  <= '0;
         carry_q   <= 1'b0;
         dbz_q     <= 1'b0;
         done_q    <= 1'b0;
         refresh_q <= '0;
         idx_q     <= '0;
         anode_q   <= ~DIGITS'(1);
         led_q     <= 7'b0000001;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         result_q  <= result_d;
         carry_q   <= carry_d;
         dbz_q     <= dbz_d;
         done_q    <= done_d;
         refresh_q <= refresh_d;
         idx_q     <= idx_d;
         anode_q   <= anode_d;
         led_q     <= led_d;
      end
   end

   assign io.busy           = (state_q != S_IDLE);
   assign io.done           = done_q;
   assign io.result         = result_q;
   assign io.carry          = carry_q;
   assign io.div_by_zero    = dbz_q;
   assign io.Anode_Activate = anode_q;
   assign io.LED_out        = led_q;
endmodule

// File: tb/tb_seq_alu_calc_display.sv
// Self-checking bench: directed vector table, hand-written multi-cycle corner cases,
// and random operations compared against an arithmetic reference model.
module tb_seq_alu_calc_display;
   localparam int W  = 8;
   localparam int D  = 4;
   localparam int RD = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   seq_alu_calc_display_if #(.WIDTH(W), .DIGITS(D)) io ();

   seq_alu_calc_display #(.WIDTH(W), .DIGITS(D), .REFRESH_DIV(RD)) dut (
      .clock_100Mhz(clk),
      .reset       (rst),
      .io          (io)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] last_res = '0;
   logic [6:0]  seg_tab [16];

   typedef struct {
      logic [15:0] res;
      logic        c;
      logic        dz;
      int          lat;
   } exp_t;

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [7:0]  x;
      logic [7:0]  y;
      logic [15:0] res;
      logic        c;
      logic        dz;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain integer arithmetic on the operation's definition.
   function automatic exp_t model(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
      exp_t e;
      int   xi;
      int   yi;
      xi    = int'(x);
      yi    = int'(y);
      e.c   = 1'b0;
      e.dz  = 1'b0;
      e.lat = 1;
      case (op)
         3'd0: begin e.res = 16'((xi + yi) % 256);       e.c = ((xi + yi) > 255); end
         3'd1: begin e.res = 16'((xi - yi + 256) % 256); e.c = (xi < yi);         end
         3'd2: e.res = {8'h00, x & y};
         3'd3: e.res = {8'h00, x | y};
         3'd4: e.res = {8'h00, x ^ y};
         3'd5: begin e.res = 16'(xi * yi); e.lat = W + 1; end
         3'd6: begin
            e.lat = W + 1;
            if (yi == 0) begin
               e.res = {x, 8'hFF};
               e.dz  = 1'b1;
            end else begin
               e.res = 16'((xi % yi) * 256 + xi / yi);
            end
         end
         default: e.res = {8'h00, x};
      endcase
      return e;
   endfunction

   task automatic run_op(input string name, input logic [2:0] op, input logic [7:0] x,
                         input logic [7:0] y, input exp_t e, input bit perturb);
      int lat    = 0;
      int busy_n = 0;
      bit seen   = 1'b0;
      io.X     = x;
      io.Y     = y;
      io.Op    = op;
      io.start = 1'b1;
      for (int i = 0; i < 20 && !seen; i++) begin
         step();
         io.start = 1'b0;
         if (perturb) begin
            io.X  = 8'($urandom);
            io.Y  = 8'($urandom);
            io.Op = 3'($urandom);
         end
         lat++;
         if (io.busy) busy_n++;
         if (io.done) seen = 1'b1;
      end
      check({name, "_latency"}, lat, e.lat);
      check({name, "_busy_cycles"}, busy_n, e.lat - 1);
      check({name, "_result"}, io.result, e.res);
      check({name, "_carry"}, io.carry, e.c);
      check({name, "_div_by_zero"}, io.div_by_zero, e.dz);
      step();
      check({name, "_done_one_cycle"}, io.done, 1'b0);
      last_res = e.res;
   endtask

   task automatic check_display(input string name);
      logic [3:0] want_an;
      for (int d = 0; d < D; d++) begin
         int n = 0;
         want_an = ~(4'b0001 << d);
         while (io.Anode_Activate !== want_an && n < 4 * RD * D) begin
            step();
            n++;
         end
         check($sformatf("%s_anode%0d", name, d), io.Anode_Activate, want_an);
         check($sformatf("%s_seg%0d", name, d), io.LED_out, seg_tab[last_res[4*d +: 4]]);
      end
   endtask

   initial begin
      int   dn;
      exp_t e;
      logic [2:0] op;
      logic [7:0] x;
      logic [7:0] y;

      seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                  7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                  7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                  7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

      vecs[0]  = '{"add_wrap",  3'd0, 8'hF0, 8'h20, 16'h0010, 1'b1, 1'b0};
      vecs[1]  = '{"sub_borrow",3'd1, 8'h05, 8'h07, 16'h00FE, 1'b1, 1'b0};
      vecs[2]  = '{"sub_plain", 3'd1, 8'h07, 8'h05, 16'h0002, 1'b0, 1'b0};
      vecs[3]  = '{"add_plain", 3'd0, 8'h12, 8'h34, 16'h0046, 1'b0, 1'b0};
      vecs[4]  = '{"and",       3'd2, 8'hF0, 8'h3C, 16'h0030, 1'b0, 1'b0};
      vecs[5]  = '{"or",        3'd3, 8'h0F, 8'h30, 16'h003F, 1'b0, 1'b0};
      vecs[6]  = '{"xor",       3'd4, 8'hFF, 8'h0F, 16'h00F0, 1'b0, 1'b0};
      vecs[7]  = '{"pass",      3'd7, 8'h5A, 8'hC3, 16'h005A, 1'b0, 1'b0};
      vecs[8]  = '{"div_100_7", 3'd6, 8'd100, 8'd7, 16'h020E, 1'b0, 1'b0};
      vecs[9]  = '{"div_zero",  3'd6, 8'h33, 8'h00, 16'h33FF, 1'b0, 1'b1};
      vecs[10] = '{"mul_0f_11", 3'd5, 8'h0F, 8'h11, 16'h00FF, 1'b0, 1'b0};
      vecs[11] = '{"mul_zero",  3'd5, 8'h00, 8'hFF, 16'h0000, 1'b0, 1'b0};

      io.X = '0; io.Y = '0; io.Op = '0; io.start = 1'b0;
      rst = 1'b1;
      step();
      step();
      check("rst_busy", io.busy, 1'b0);
      check("rst_done", io.done, 1'b0);
      check("rst_result", io.result, 16'h0000);
      check("rst_carry", io.carry, 1'b0);
      check("rst_dbz", io.div_by_zero, 1'b0);
      check("rst_anode", io.Anode_Activate, 4'b1110);
      check("rst_led", io.LED_out, 7'b0000001);
      rst = 1'b0;

      repeat (4) step();
      check("scan_after4_anode", io.Anode_Activate, 4'b1101);
      repeat (12) step();
      check("scan_after16_anode", io.Anode_Activate, 4'b1110);

      foreach (vecs[i]) begin
         e.res = vecs[i].res;
         e.c   = vecs[i].c;
         e.dz  = vecs[i].dz;
         e.lat = (vecs[i].op == 3'd5 || vecs[i].op == 3'd6) ? W + 1 : 1;
         run_op(vecs[i].name, vecs[i].op, vecs[i].x, vecs[i].y, e, 1'b0);
      end

      // Largest product, then scan every digit of it.
      run_op("mul_ff_ff", 3'd5, 8'hFF, 8'hFF, model(3'd5, 8'hFF, 8'hFF), 1'b1);
      check_display("disp_fe01");

      for (int i = 0; i < 30; i++) begin
         op = 3'($urandom_range(0, 7));
         x  = 8'($urandom);
         y  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         run_op($sformatf("rand%0d_op%0d", i, op), op, x, y, model(op, x, y), 1'b1);
      end
      check_display("disp_rand");

      // A start during a multiply must be dropped, not queued.
      io.X = 8'd3; io.Y = 8'd5; io.Op = 3'd5; io.start = 1'b1;
      step();
      io.start = 1'b0;
      step();
      io.start = 1'b1; io.Op = 3'd0; io.X = 8'hAA;
      step();
      io.start = 1'b0;
      dn = 0;
      repeat (15) begin
         step();
         if (io.done) dn++;
      end
      check("ignore_start_done_count", dn, 1);
      check("ignore_start_result", io.result, 16'd15);
      check("ignore_start_idle", io.busy, 1'b0);
      last_res = 16'd15;

      // Reset on the fourth busy cycle of a divide aborts it silently.
      io.X = 8'd100; io.Y = 8'd7; io.Op = 3'd6; io.start = 1'b1;
      step();
      io.start = 1'b0;
      repeat (3) step();
      check("abort_was_busy", io.busy, 1'b1);
      rst = 1'b1;
      step();
      check("abort_busy", io.busy, 1'b0);
      check("abort_done", io.done, 1'b0);
      check("abort_result", io.result, 16'h0000);
      check("abort_anode", io.Anode_Activate, 4'b1110);
      check("abort_led", io.LED_out, 7'b0000001);
      rst = 1'b0;
      dn = 0;
      repeat (15) begin
         step();
         if (io.done) dn++;
      end
      check("abort_no_done", dn, 0);
      check("abort_result_held", io.result, 16'h0000);
      last_res = 16'h0000;

      run_op("after_abort_add", 3'd0, 8'h01, 8'h02, model(3'd0, 8'h01, 8'h02), 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
